// File: rtl/node_program_loader.sv
// Configuration loader for a T21 node grid: decodes a 16-bit command/program stream
// into per-node program-memory writes, zero-fills unused addresses and owns node reset.
module node_program_loader #(
    parameter int NUM_NODES = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 node_rst,
    output logic [3:0]           instr_addr,
    output logic [15:0]          instr_data,
    output logic [NUM_NODES-1:0] write_instr,
    output logic                 busy,
    output logic                 running,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ZFILL
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_target, w_target_nxt;
    logic [3:0]            r_last, w_last_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic                  r_node_rst, w_node_rst_nxt;
    logic [3:0]            r_addr, w_addr_nxt;
    logic [15:0]           r_data, w_data_nxt;
    logic [NUM_NODES-1:0]  r_wr, w_wr_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_accept;
    logic [NUM_NODES-1:0]  w_onehot;

    assign cfg_ready   = !rst && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_accept    = cfg_valid && cfg_ready;
    assign w_onehot    = NUM_NODES'(1) << r_target;
    assign node_rst    = r_node_rst;
    assign running     = ~r_node_rst;
    assign instr_addr  = r_addr;
    assign instr_data  = r_data;
    assign write_instr = r_wr;
    assign busy        = (r_state == S_LOAD) || (r_state == S_ZFILL);
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_last     <= '0;
            r_cnt      <= '0;
            r_node_rst <= 1'b1;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr       <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_node_rst <= w_node_rst_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_wr       <= w_wr_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_node_rst_nxt = r_node_rst;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_wr_nxt       = '0;
        w_err_nxt      = r_err;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cfg_data[15:12])
                        4'hA: begin
                            if (32'(cfg_data[11:4]) >= NUM_NODES) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_target_nxt   = cfg_data[11:4];
                                w_last_nxt     = cfg_data[3:0];
                                w_cnt_nxt      = '0;
                                w_node_rst_nxt = 1'b1;
                                w_state_nxt    = S_LOAD;
                            end
                        end
                        4'hB:    w_node_rst_nxt = 1'b0;
                        4'hC:    w_node_rst_nxt = 1'b1;
                        default: w_err_nxt      = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_wr_nxt   = w_onehot;
                    w_addr_nxt = r_cnt;
                    w_data_nxt = cfg_data;
                    w_cnt_nxt  = r_cnt + 4'd1;
                    if (r_cnt == r_last)
                        w_state_nxt = (r_last == 4'hF) ? S_IDLE : S_ZFILL;
                end
            end
            S_ZFILL: begin
                // Counter already points at N, so the first zero write follows the last data write directly.
                w_wr_nxt   = w_onehot;
                w_addr_nxt = r_cnt;
                w_data_nxt = '0;
                w_cnt_nxt  = r_cnt + 4'd1;
                if (r_cnt == 4'hF)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_node_program_loader.sv
// Directed self-checking bench for node_program_loader (NUM_NODES = 12).
module tb_node_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        node_rst;
    logic [3:0]  instr_addr;
    logic [15:0] instr_data;
    logic [11:0] write_instr;
    logic        busy;
    logic        running;
    logic        err;

    int checks = 0;
    int errors = 0;

    node_program_loader #(.NUM_NODES(12)) dut (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .node_rst(node_rst), .instr_addr(instr_addr),
        .instr_data(instr_data), .write_instr(write_instr), .busy(busy),
        .running(running), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
        step(); step();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", cfg_ready); end
        rst = 1'b0; #1;
        checks++; if (node_rst !== 1'b1) begin errors++; $display("FAIL rst_node_rst: got %b expected 1", node_rst); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b expected 0", running); end
        checks++; if (write_instr !== 12'h000) begin errors++; $display("FAIL rst_wr: got %h expected 000", write_instr); end
        checks++; if (instr_addr !== 4'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", instr_addr); end
        checks++; if (instr_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h expected 0000", instr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rel: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_load_short();
        logic [15:0] words [3];
        words[0] = 16'h8801; words[1] = 16'hE000; words[2] = 16'hC000;
        cfg_valid = 1'b1; cfg_data = 16'hA022;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL short_busy: got %b expected 1", busy); end
        checks++; if (write_instr !== 12'h000) begin errors++; $display("FAIL short_hdr_wr: got %h expected 000", write_instr); end
        for (int k = 0; k < 3; k++) begin
            cfg_data = words[k];
            step();
            checks++;
            if (write_instr !== 12'h004 || instr_addr !== 4'(k) || instr_data !== words[k]) begin
                errors++;
                $display("FAIL short_word%0d: got wr=%h addr=%h data=%h expected wr=004 addr=%h data=%h",
                         k, write_instr, instr_addr, instr_data, k, words[k]);
            end
        end
        cfg_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL zfill_ready%0d: got %b expected 0", k, cfg_ready); end
            step();
            checks++;
            if (write_instr !== 12'h004 || instr_addr !== 4'(2 + k) || instr_data !== 16'h0000) begin
                errors++;
                $display("FAIL zfill_addr%0d: got wr=%h addr=%h data=%h expected wr=004 addr=%h data=0000",
                         2 + k, write_instr, instr_addr, instr_data, 2 + k);
            end
        end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL zfill_end_ready: got %b expected 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zfill_end_busy: got %b expected 0", busy); end
        step();
        checks++; if (write_instr !== 12'h000) begin errors++; $display("FAIL short_after_wr: got %h expected 000", write_instr); end
        checks++; if (instr_addr !== 4'hF) begin errors++; $display("FAIL short_addr_hold: got %h expected f", instr_addr); end
        checks++; if (node_rst !== 1'b1) begin errors++; $display("FAIL short_still_halted: got %b expected 1", node_rst); end
    endtask

    task automatic test_run_halt();
        cfg_valid = 1'b1; cfg_data = 16'hB000;
        step();
        checks++; if (node_rst !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL run1: got node_rst=%b running=%b expected 0/1", node_rst, running); end
        step();
        checks++; if (node_rst !== 1'b0 || running !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL run2: got node_rst=%b running=%b err=%b expected 0/1/0", node_rst, running, err); end
        cfg_data = 16'hC000;
        step();
        checks++; if (node_rst !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL halt1: got node_rst=%b running=%b expected 1/0", node_rst, running); end
        step();
        checks++; if (node_rst !== 1'b1) begin errors++; $display("FAIL halt2: got %b expected 1", node_rst); end
        cfg_data = 16'hB000;
        step();
        cfg_valid = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL rerun: got %b expected 1", running); end
    endtask

    task automatic test_load_full(input logic [7:0] node, input logic [11:0] exp_wr, input logic exp_err);
        cfg_valid = 1'b1; cfg_data = {4'hA, node, 4'hF};
        step();
        checks++; if (node_rst !== 1'b1) begin errors++; $display("FAIL full%0d_halt: got %b expected 1", node, node_rst); end
        for (int k = 0; k < 16; k++) begin
            cfg_data = 16'h1000 + 16'(k * 3);
            step();
            checks++;
            if (write_instr !== exp_wr || instr_addr !== 4'(k) || instr_data !== 16'h1000 + 16'(k * 3)) begin
                errors++;
                $display("FAIL full%0d_word%0d: got wr=%h addr=%h data=%h expected wr=%h addr=%h data=%h",
                         node, k, write_instr, instr_addr, instr_data, exp_wr, k, 16'h1000 + 16'(k * 3));
            end
        end
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL full%0d_nozfill: got busy=%b ready=%b expected 0/1", node, busy, cfg_ready); end
        cfg_valid = 1'b0;
        step();
        checks++; if (write_instr !== 12'h000) begin errors++; $display("FAIL full%0d_after_wr: got %h expected 000", node, write_instr); end
        checks++; if (node_rst !== 1'b1) begin errors++; $display("FAIL full%0d_held: got %b expected 1", node, node_rst); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL full%0d_err: got %b expected %b", node, err, exp_err); end
    endtask

    task automatic test_bad_index();
        cfg_valid = 1'b1; cfg_data = 16'hA0C0;
        step();
        cfg_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badidx_err: got %b expected 1", err); end
        checks++; if (write_instr !== 12'h000) begin errors++; $display("FAIL badidx_wr: got %h expected 000", write_instr); end
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL badidx_idle: got busy=%b ready=%b expected 0/1", busy, cfg_ready); end
        test_load_full(8'd11, 12'h800, 1'b1);
    endtask

    task automatic test_stall();
        int strobes = 0;
        int n = 0;
        cfg_valid = 1'b1; cfg_data = 16'hA053;
        step();
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1'b1; cfg_data = 16'h4400 + 16'(k);
            step();
            checks++;
            if (write_instr !== 12'h020 || instr_addr !== 4'(k) || instr_data !== 16'h4400 + 16'(k)) begin
                errors++;
                $display("FAIL stall_word%0d: got wr=%h addr=%h data=%h expected wr=020 addr=%h data=%h",
                         k, write_instr, instr_addr, instr_data, k, 16'h4400 + 16'(k));
            end
            if (k < 3) begin
                cfg_valid = 1'b0; cfg_data = 16'hFFFF;
                for (int g = 0; g < 2; g++) begin
                    step();
                    checks++;
                    if (write_instr !== 12'h000 || instr_addr !== 4'(k)) begin
                        errors++;
                        $display("FAIL stall_gap%0d_%0d: got wr=%h addr=%h expected wr=000 addr=%h", k, g, write_instr, instr_addr, k);
                    end
                end
            end
        end
        cfg_valid = 1'b0;
        while (busy && n < 30) begin
            step(); n++;
            if (write_instr != 12'h000) strobes++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_timeout: got busy=%b expected 0", busy); end
        checks++; if (strobes != 12) begin errors++; $display("FAIL stall_zfill_count: got %0d expected 12", strobes); end
    endtask

    task automatic test_rst_zfill();
        int n = 0;
        cfg_valid = 1'b1; cfg_data = 16'hA031;
        step();
        cfg_data = 16'h1111; step();
        cfg_data = 16'h2222; step();
        cfg_valid = 1'b0;
        while (instr_addr != 4'h7 && n < 30) begin step(); n++; end
        checks++; if (instr_addr !== 4'h7 || write_instr !== 12'h008) begin errors++; $display("FAIL rstz_reach: got addr=%h wr=%h expected 7/008", instr_addr, write_instr); end
        rst = 1'b1;
        step();
        checks++; if (write_instr !== 12'h000) begin errors++; $display("FAIL rstz_wr: got %h expected 000", write_instr); end
        checks++; if (node_rst !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rstz_state: got node_rst=%b err=%b expected 1/0", node_rst, err); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstz_ready_in_rst: got %b expected 0", cfg_ready); end
        step();
        rst = 1'b0; #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstz_ready: got %b expected 1", cfg_ready); end
        step();
        checks++; if (write_instr !== 12'h000 || busy !== 1'b0) begin errors++; $display("FAIL rstz_quiet: got wr=%h busy=%b expected 000/0", write_instr, busy); end
    endtask

    task automatic test_bad_opcode();
        cfg_valid = 1'b1; cfg_data = 16'h5123;
        step();
        cfg_valid = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0 || write_instr !== 12'h000) begin errors++; $display("FAIL badop: got err=%b busy=%b wr=%h expected 1/0/000", err, busy, write_instr); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badop_sticky: got %b expected 1", err); end
    endtask

    initial begin
        test_reset();
        test_load_short();
        test_run_halt();
        test_load_full(8'd0, 12'h001, 1'b0);
        test_bad_index();
        test_stall();
        test_rst_zfill();
        test_bad_opcode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
